// File: rtl/dff_pkg.sv
// Shared definitions for the dff_counter slice.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   DEFAULT_WIDTH        : default counter width
//   pcnt_w()             : prescaler counter width, never below 1 bit
package dff_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SAT      = 1;
    localparam int DEFAULT_WIDTH = 4;

    // Width needed to hold 0..prescale-1. Clamped to 1 so a declaration
    // using it is never zero-width.
    function automatic int pcnt_w(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/dff_prescaler.sv
// Prescaler for dff_counter: produces one tick every PRESCALE enabled,
// non-restarted cycles.
// Ports:
//   clk     in  clock
//   rstb    in  synchronous active-high reset
//   in      in  enable; the count holds while low
//   restart in  synchronous restart of the period (clear or load)
//   tick    out combinational: a count step happens at the next edge
module dff_prescaler
    import dff_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstb,
    input  logic in,
    input  logic restart,
    output logic tick
);

    localparam int PCNT_W = pcnt_w(PRESCALE);

    generate
        if (PRESCALE > 1) begin : g_div
            localparam logic [PCNT_W-1:0] LAST = PCNT_W'(PRESCALE - 1);

            logic [PCNT_W-1:0] pcnt_q;
            logic [PCNT_W-1:0] pcnt_d;

            assign tick = in & ~restart & ~rstb & (pcnt_q == LAST);

            always_comb begin
                pcnt_d = pcnt_q;
                if (restart)
                    pcnt_d = '0;
                else if (in)
                    pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (rstb)
                    pcnt_q <= '0;
                else
                    pcnt_q <= pcnt_d;
            end
        end else begin : g_nodiv
            // Every enabled cycle steps; no state is needed at all.
            logic unused_clk;
            assign unused_clk = clk;
            assign tick       = in & ~restart & ~rstb;
        end
    endgenerate

endmodule

// File: rtl/dff_counter.sv
// WIDTH-bit loadable up/down counter register with prescaler, modulus
// MAX_VAL, wrap or saturate at the bounds, terminal count and a sticky
// over/underflow flag.
// Ports:
//   clk  in  clock
//   rstb in  synchronous active-high reset
//   in   in  enable; gates load and counting
//   ld   in  load request (needs in=1)
//   D    in  load value, clamped to MAX_VAL
//   up   in  direction, 1 = increment
//   clr  in  synchronous clear, independent of in
//   Q    out counter value (registered)
//   nQ   out ~Q
//   tc   out terminal count for the current direction
//   tick out a count step happens at the next edge
//   ovf  out sticky over/underflow flag
module dff_counter
    import dff_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_VAL   = (1 << WIDTH) - 1,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = MODE_WRAP,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             in,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    input  logic             up,
    input  logic             clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             tc,
    output logic             tick,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam bit               SAT   = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             load;
    logic             at_max, at_zero;

    assign load    = in & ld;
    assign at_max  = (q_q == MAX_Q);
    assign at_zero = (q_q == '0);

    dff_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk     (clk),
        .rstb    (rstb),
        .in      (in),
        .restart (clr | load),
        .tick    (tick)
    );

    // Reset is applied in the register block; this covers clr > load > step.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            q_d = (D > MAX_Q) ? MAX_Q : D;
        end else if (tick) begin
            if (up) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    q_d   = SAT ? MAX_Q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    q_d   = SAT ? '0 : MAX_Q;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            q_q   <= RST_Q;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign nQ  = ~q_q;
    assign ovf = ovf_q;
    assign tc  = (up & at_max) | (~up & at_zero);

endmodule

// File: tb/tb_dff_counter.sv
module tb_dff_counter;
    import dff_pkg::*;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rstb, clr, en, ld, up;
    logic [3:0] D;

    logic [3:0] q  [N];
    logic [3:0] nq [N];
    logic       tc [N];
    logic       tk [N];
    logic       ov [N];

    // Per-instance configuration and model state.
    int maxv [N] = '{9, 9, 15};
    int pre  [N] = '{1, 1, 3};
    int sat  [N] = '{0, 1, 0};
    int rv   [N] = '{5, 0, 0};
    int mq   [N];
    int mp   [N];
    int movf [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(MODE_WRAP), .RESET_VAL(5)) u0 (
        .clk(clk), .rstb(rstb), .in(en), .ld(ld), .D(D), .up(up), .clr(clr),
        .Q(q[0]), .nQ(nq[0]), .tc(tc[0]), .tick(tk[0]), .ovf(ov[0]));

    dff_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(MODE_SAT), .RESET_VAL(0)) u1 (
        .clk(clk), .rstb(rstb), .in(en), .ld(ld), .D(D), .up(up), .clr(clr),
        .Q(q[1]), .nQ(nq[1]), .tc(tc[1]), .tick(tk[1]), .ovf(ov[1]));

    dff_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(3), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u2 (
        .clk(clk), .rstb(rstb), .in(en), .ld(ld), .D(D), .up(up), .clr(clr),
        .Q(q[2]), .nQ(nq[2]), .tc(tc[2]), .tick(tk[2]), .ovf(ov[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: does the next edge step this counter?
    function automatic int m_tick(input int k);
        return (en && !ld && !clr && !rstb && (mp[k] == pre[k] - 1)) ? 1 : 0;
    endfunction

    function automatic int m_tc(input int k);
        return ((up && mq[k] == maxv[k]) || (!up && mq[k] == 0)) ? 1 : 0;
    endfunction

    // Reference: apply one clock edge with the currently driven inputs.
    task automatic m_edge(input int k);
        int t;
        t = m_tick(k);
        if (rstb) begin
            mq[k] = rv[k]; movf[k] = 0; mp[k] = 0;
        end else if (clr) begin
            mq[k] = 0; movf[k] = 0; mp[k] = 0;
        end else if (en && ld) begin
            mq[k] = (int'(D) > maxv[k]) ? maxv[k] : int'(D);
            mp[k] = 0;
        end else if (en) begin
            if (t == 1) begin
                mp[k] = 0;
                if (up) begin
                    if (mq[k] < maxv[k]) mq[k] = mq[k] + 1;
                    else begin movf[k] = 1; if (sat[k] == 0) mq[k] = 0; end
                end else begin
                    if (mq[k] > 0) mq[k] = mq[k] - 1;
                    else begin movf[k] = 1; if (sat[k] == 0) mq[k] = maxv[k]; end
                end
            end else begin
                mp[k] = mp[k] + 1;
            end
        end
    endtask

    // One clock cycle: drive, check comb outputs, clock, check registers.
    task automatic step(input logic r, input logic c, input logic i, input logic l,
                        input logic [3:0] d, input logic u);
        rstb = r; clr = c; en = i; ld = l; D = d; up = u;
        #2;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("tick%0d", k), int'(tk[k]), m_tick(k));
            chk($sformatf("tc%0d", k), int'(tc[k]), m_tc(k));
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) m_edge(k);
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("q%0d", k), int'(q[k]), mq[k]);
            chk($sformatf("nq%0d", k), int'(nq[k]), (~mq[k]) & 15);
            chk($sformatf("ovf%0d", k), int'(ov[k]), movf[k]);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin mq[k] = 0; mp[k] = 0; movf[k] = 0; end

        // Reset
        step(1, 0, 0, 0, 4'h0, 1);
        chk("rst_q0", int'(q[0]), 5);
        chk("rst_nq0", int'(nq[0]), 4'hA);
        chk("rst_ovf0", int'(ov[0]), 0);

        // Wrap / saturate up from 0
        step(0, 1, 0, 0, 4'h0, 1);
        for (int n = 0; n < 10; n++) step(0, 0, 1, 0, 4'h0, 1);
        chk("wrap_q0", int'(q[0]), 0);
        chk("wrap_ovf0", int'(ov[0]), 1);
        chk("sat_q1", int'(q[1]), 9);
        chk("sat_ovf1", int'(ov[1]), 1);
        chk("presc_q2", int'(q[2]), 3);
        step(0, 0, 1, 0, 4'h0, 1);
        chk("ovf_sticky0", int'(ov[0]), 1);

        // Saturate down from 2
        step(0, 1, 0, 0, 4'h0, 0);
        step(0, 0, 1, 1, 4'h2, 0);
        step(0, 0, 1, 0, 4'h0, 0);
        step(0, 0, 1, 0, 4'h0, 0);
        chk("satdn_ovf_pre", int'(ov[1]), 0);
        step(0, 0, 1, 0, 4'h0, 0);
        chk("satdn_q1", int'(q[1]), 0);
        chk("satdn_ovf1", int'(ov[1]), 1);
        step(0, 1, 0, 0, 4'h0, 0);
        chk("clr_ovf1", int'(ov[1]), 0);

        // Prescaler period stretched by disabled cycles
        step(0, 0, 1, 0, 4'h0, 1);
        step(0, 0, 1, 0, 4'h0, 1);
        chk("presc_hold_a", int'(q[2]), 0);
        step(0, 0, 0, 0, 4'h0, 1);
        step(0, 0, 0, 0, 4'h0, 1);
        chk("presc_hold_b", int'(q[2]), 0);
        step(0, 0, 1, 0, 4'h0, 1);
        chk("presc_step", int'(q[2]), 1);

        // Load clamp and priority
        step(0, 0, 1, 1, 4'hF, 1);
        chk("clamp_q0", int'(q[0]), 9);
        chk("noclamp_q2", int'(q[2]), 15);
        step(0, 1, 1, 1, 4'hF, 1);
        chk("clr_over_ld", int'(q[0]), 0);
        step(0, 0, 0, 1, 4'h5, 1);
        chk("ld_needs_en", int'(q[0]), 0);

        // Direction flip at the top bound
        step(0, 0, 1, 1, 4'h9, 1);
        step(0, 0, 1, 0, 4'h0, 0);
        chk("flip_q0", int'(q[0]), 8);
        chk("flip_ovf0", int'(ov[0]), 0);

        // Reset in the middle of counting
        step(0, 0, 1, 1, 4'h7, 1);
        step(1, 0, 1, 0, 4'h0, 1);
        chk("midrst_q0", int'(q[0]), 5);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
